// File: rtl/lab2_5_src.sv
// lab2_5_src: burst stimulus source for the lab2_5 3-bit symbol detector.
// On start it emits LEN symbols (count-up, count-down, LFSR or hold) from a
// seed, then waits LAT clocks for the detector response to drain. While the
// burst is in flight it counts z=1 samples and latches any detector error.
// Optional build macro LAB2_5_SRC_ZIDLE_EN: x floats (3'bzzz) whenever no
// burst symbol is on it, so the detector input can sit on a shared bus.
// Without the macro x idles at 3'b000.
module lab2_5_src #(
  parameter int LEN = 8,  // symbols per burst, 1..15
  parameter int LAT = 1   // detector latency in clocks, 0..3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [2:0] seed,
  output logic [2:0] x,
  output logic       x_valid,
  output logic       busy,
  output logic       done,
  input  logic       z,
  input  logic       error,
  output logic [3:0] z_cnt,
  output logic       err_seen
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(LEN - 1);
  localparam logic [3:0] DRN_IDX  = 4'((LAT > 0) ? (LAT - 1) : 0);

  state_t     r_state;
  state_t     w_nxt;
  logic [3:0] r_idx;
  logic [2:0] r_x;
  logic       r_vld;
  logic [1:0] r_mode;
  logic       r_done;
  logic [3:0] r_zcnt;
  logic       r_err;
  logic       w_smp;
  logic       w_busy;
  logic       w_last;
  logic       w_drn_end;
  logic       w_go;
  logic [2:0] w_seed_ld;

  // Next symbol of the running sequence for the latched mode.
  function automatic logic [2:0] next_sym(input logic [1:0] m, input logic [2:0] v);
    case (m)
      2'd0:    next_sym = v + 3'd1;
      2'd1:    next_sym = v - 3'd1;
      2'd2:    next_sym = {v[1:0], v[2] ^ v[1]};
      default: next_sym = v;
    endcase
  endfunction

  // Hit counter increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    sat_inc = (c == 4'd15) ? 4'd15 : c + 4'd1;
  endfunction

  assign w_last    = (r_idx == LAST_IDX);
  assign w_drn_end = (r_idx == DRN_IDX);
  assign w_go      = (r_state == S_IDLE) && start;
  // The all-zero state would lock the LFSR, so a zero seed starts it at 1.
  assign w_seed_ld = ((mode == 2'd2) && (seed == 3'd0)) ? 3'd1 : seed;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nxt = S_RUN;
      S_RUN:   if (w_last) w_nxt = (LAT > 0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (w_drn_end) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_busy = (r_state == S_RUN) || (r_state == S_DRAIN);
  end

  // Symbol generator and index counter; idx is reused to time the drain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x    <= 3'd0;
      r_vld  <= 1'b0;
      r_idx  <= 4'd0;
      r_mode <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x    <= w_seed_ld;
            r_vld  <= 1'b1;
            r_idx  <= 4'd0;
            r_mode <= mode;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_x   <= 3'd0;
            r_vld <= 1'b0;
            r_idx <= 4'd0;
          end else begin
            r_x   <= next_sym(r_mode, r_x);
            r_idx <= r_idx + 4'd1;
          end
        end
        S_DRAIN: r_idx <= r_idx + 4'd1;
        default: r_idx <= 4'd0;
      endcase
    end
  end

  // Completion pulse, registered one clock after the DONE state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_done <= 1'b0;
    else          r_done <= (r_state == S_DONE);
  end

  // Align x_valid with the detector response to form the sample strobe.
  generate
    if (LAT == 0) begin : g_nodly
      assign w_smp = r_vld;
    end else begin : g_dly
      logic [LAT-1:0] r_dly;
      // LAT-deep shift register of x_valid.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_dly <= '0;
        else          r_dly <= (r_dly << 1) | LAT'(r_vld);
      end
      assign w_smp = r_dly[LAT-1];
    end
  endgenerate

  // Response monitor: cleared on start, counts hits and latches errors.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_zcnt <= 4'd0;
      r_err  <= 1'b0;
    end else if (w_go) begin
      r_zcnt <= 4'd0;
      r_err  <= 1'b0;
    end else if (w_smp) begin
      if (z)     r_zcnt <= sat_inc(r_zcnt);
      if (error) r_err  <= 1'b1;
    end
  end

`ifdef LAB2_5_SRC_ZIDLE_EN
  assign x = r_vld ? r_x : 3'bzzz;
`else
  assign x = r_vld ? r_x : 3'b000;
`endif

  assign x_valid  = r_vld;
  assign busy     = w_busy;
  assign done     = r_done;
  assign z_cnt    = r_zcnt;
  assign err_seen = r_err;

endmodule

// File: tb/tb_lab2_5_src.sv
// Bench for lab2_5_src: scoreboard of expected symbols per burst plus a
// latency-1 detector model that answers from per-symbol z/error patterns.
module tb_lab2_5_src;

  localparam int LEN = 8;
  localparam int LAT = 1;
  localparam int P   = LEN + LAT + 2;  // start-to-start period with start held
`ifdef LAB2_5_SRC_ZIDLE_EN
  localparam logic [2:0] IDLE_X = 3'bzzz;
`else
  localparam logic [2:0] IDLE_X = 3'b000;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] seed = 3'd0;
  logic [2:0] x;
  logic       x_valid, busy, done, z, error, err_seen;
  logic [3:0] z_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] exp_q[$];

  logic [LEN-1:0] z_pat = '0;
  logic [LEN-1:0] e_pat = '0;
  logic           z_out = 1'b0;
  logic           det_v = 1'b0;
  int             det_i = 0;
  int             sym_cnt = 0;

  lab2_5_src #(.LEN(LEN), .LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .seed(seed),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done), .z(z), .error(error),
    .z_cnt(z_cnt), .err_seen(err_seen)
  );

  always #5 clock = ~clock;

  // Detector model: answers symbol k one clock after it was presented.
  always @(posedge clock) begin
    det_v   <= x_valid;
    det_i   <= sym_cnt;
    sym_cnt <= x_valid ? sym_cnt + 1 : 0;
  end
  assign z     = det_v ? z_pat[det_i] : z_out;
  assign error = det_v ? e_pat[det_i] : 1'b0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] model_next(input logic [1:0] m, input logic [2:0] v);
    int tab[7] = '{1, 2, 5, 3, 7, 6, 4};
    case (m)
      2'd0: return 3'((int'(v) + 1) % 8);
      2'd1: return 3'((int'(v) + 7) % 8);
      2'd2: begin
        for (int i = 0; i < 7; i++) if (tab[i] == int'(v)) return 3'(tab[(i + 1) % 7]);
        return 3'd0;
      end
      default: return v;
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] m, input logic [2:0] s);
    logic [2:0] v;
    v = (m == 2'd2 && s == 3'd0) ? 3'd1 : s;
    for (int k = 0; k < LEN; k++) begin
      exp_q.push_back(v);
      v = model_next(m, v);
    end
  endtask

  // Request a burst; afterwards scramble mode/seed to show they were latched.
  task automatic start_burst(input logic [1:0] m, input logic [2:0] s, input bit hold);
    @(negedge clock);
    mode = m; seed = s; start = 1'b1;
    push_exp(m, s);
    @(posedge clock);
    #1;
    if (!hold) begin
      mode = ~m; seed = ~s; start = 1'b0;
    end
  endtask

  // Follow one burst from the start edge until a few clocks after done.
  task automatic watch_burst(input string nm, input int exp_z, input bit exp_e);
    logic [2:0] e;
    int ndone = 0;
    for (int c = 0; c <= LEN + LAT + 3; c++) begin
      @(negedge clock);
      vectors++;
      if (x_valid !== (c < LEN)) begin
        miscompares++;
        $display("FAIL %s x_valid c=%0d got %b want %b", nm, c, x_valid, (c < LEN));
      end
      vectors++;
      if (x_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s x c=%0d got %0d want nothing (queue empty)", nm, c, x);
        end else begin
          e = exp_q.pop_front();
          if (x !== e) begin
            miscompares++;
            $display("FAIL %s x c=%0d got %0d want %0d", nm, c, x, e);
          end
        end
      end else if (x !== IDLE_X) begin
        miscompares++;
        $display("FAIL %s x_idle c=%0d got %b want %b", nm, c, x, IDLE_X);
      end
      vectors++;
      if (busy !== (c < LEN + LAT)) begin
        miscompares++;
        $display("FAIL %s busy c=%0d got %b want %b", nm, c, busy, (c < LEN + LAT));
      end
      vectors++;
      if (done !== (c == LEN + LAT + 1)) begin
        miscompares++;
        $display("FAIL %s done c=%0d got %b want %b", nm, c, done, (c == LEN + LAT + 1));
      end
      if (done === 1'b1) ndone++;
      if (c == 0) begin
        vectors++;
        if (z_cnt !== 4'd0 || err_seen !== 1'b0) begin
          miscompares++;
          $display("FAIL %s clear_on_start got z_cnt=%0d err=%b want 0/0", nm, z_cnt, err_seen);
        end
      end
    end
    vectors++;
    if (ndone != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s pulses/left got %0d/%0d want 1/0", nm, ndone, exp_q.size());
    end
    vectors++;
    if (z_cnt !== 4'(exp_z) || err_seen !== exp_e) begin
      miscompares++;
      $display("FAIL %s monitor got z_cnt=%0d err=%b want %0d/%b", nm, z_cnt, err_seen, exp_z, exp_e);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if (x !== IDLE_X || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        z_cnt !== 4'd0 || err_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset got x=%b v=%b busy=%b done=%b z_cnt=%0d err=%b want idle/0", x, x_valid,
               busy, done, z_cnt, err_seen);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_mode_up;
    z_pat = '0; e_pat = '0; z_out = 1'b0;
    start_burst(2'd0, 3'd0, 1'b0);
    watch_burst("up", 0, 1'b0);
  endtask

  task automatic test_mode_down;
    start_burst(2'd1, 3'd1, 1'b0);
    watch_burst("down", 0, 1'b0);
  endtask

  task automatic test_lfsr;
    start_burst(2'd2, 3'd0, 1'b0);
    watch_burst("lfsr", 0, 1'b0);
  endtask

  task automatic test_hold;
    start_burst(2'd3, 3'd5, 1'b0);
    watch_burst("hold", 0, 1'b0);
  endtask

  task automatic test_monitor;
    z_pat = 8'b1001_0010; e_pat = 8'b0010_0000; z_out = 1'b1;
    start_burst(2'd2, 3'd5, 1'b0);
    watch_burst("monitor", 3, 1'b1);
    z_pat = '0; e_pat = '0; z_out = 1'b0;
    start_burst(2'd3, 3'd6, 1'b0);
    watch_burst("monitor_clr", 0, 1'b0);
  endtask

  task automatic test_mid_start;
    start_burst(2'd0, 3'd6, 1'b0);
    fork
      watch_burst("mid_start", 0, 1'b0);
      begin
        repeat (3) @(negedge clock);
        #1 start = 1'b1;
        @(negedge clock);
        #1 start = 1'b0;
        repeat (LEN + LAT - 3) @(negedge clock);
        #1 start = 1'b1;
        @(negedge clock);
        #1 start = 1'b0;
      end
    join
  endtask

  task automatic test_back_to_back;
    logic [2:0] e;
    int ndone = 0;
    int ph;
    bit ev, ed;
    push_exp(2'd0, 3'd2);
    push_exp(2'd0, 3'd2);
    start_burst(2'd0, 3'd2, 1'b1);
    for (int c = 0; c < 3 * P + 2; c++) begin
      @(negedge clock);
      ph = c % P;
      ev = (ph < LEN) && (c < 3 * P);
      ed = (ph == LEN + LAT + 1) && (c < 3 * P);
      vectors++;
      if (x_valid !== ev || done !== ed) begin
        miscompares++;
        $display("FAIL b2b c=%0d got v=%b done=%b want v=%b done=%b", c, x_valid, done, ev, ed);
      end
      if (x_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (x !== e) begin
          miscompares++;
          $display("FAIL b2b x c=%0d got %0d want %0d", c, x, e);
        end
      end
      if (done === 1'b1) ndone++;
      if (c == 2 * P) start = 1'b0;
    end
    vectors++;
    if (ndone != 3 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b pulses/left got %0d/%0d want 3/0", ndone, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    z_pat = '1; e_pat = '1; z_out = 1'b0;
    start_burst(2'd0, 3'd3, 1'b0);
    repeat (3) @(negedge clock);
    vectors++;
    if (x !== 3'd5 || z_cnt !== 4'd1 || err_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset got x=%0d z_cnt=%0d err=%b want 5/1/1", x, z_cnt, err_seen);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (x !== IDLE_X || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        z_cnt !== 4'd0 || err_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got x=%b v=%b busy=%b done=%b z_cnt=%0d err=%b want idle/0", x,
               x_valid, busy, done, z_cnt, err_seen);
    end
    exp_q.delete();
    z_pat = '0; e_pat = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (c == 2) reset_n = 1'b1;
      vectors++;
      if (done !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset c=%0d got done=%b v=%b busy=%b want 0/0/0", c, done, x_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mode_up;
    test_mode_down;
    test_lfsr;
    test_hold;
    test_monitor;
    test_mid_start;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
